// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Merges load-use, taken-branch, data-memory wait and halt-drain hazards
// into per-stage stall/flush controls and keeps a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs,
  input  logic             id_rs_vld,
  input  logic [3:0]       id_rt,
  input  logic             id_rt_vld,
  input  logic             ex_load,
  input  logic [3:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_rdy,
  input  logic             id_halt,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALT} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             halted_q, halted_d;

  logic memwait_s, load_use_s, run_eval_s;
  logic stall_front_s, stall_all_s, flush_if_s, flush_ex_s;

  // Hazard detection: memory wait and load-use (R0 never creates a dependency).
  always_comb begin
    memwait_s  = mem_req & ~mem_rdy;
    load_use_s = ex_load && (ex_rd != 4'd0) &&
                 ((id_rs_vld && (id_rs == ex_rd)) || (id_rt_vld && (id_rt == ex_rd)));
  end

  // Next-state, drain counter and stall/flush decode from state and hazards.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    run_eval_s    = 1'b0;
    stall_front_s = 1'b0;
    stall_all_s   = 1'b0;
    flush_if_s    = 1'b0;
    flush_ex_s    = 1'b0;
    case (state_q)
      RUN: begin
        run_eval_s = 1'b1;
      end
      MEMWAIT: begin
        if (!mem_rdy) begin
          stall_all_s = 1'b1;
        end else begin
          // Completion cycle behaves exactly like RUN, so a HLT sitting in ID
          // still enters the drain instead of slipping past into EX.
          run_eval_s = 1'b1;
        end
      end
      DRAIN: begin
        if (memwait_s) begin
          stall_all_s = 1'b1;
        end else begin
          stall_front_s = 1'b1;
          flush_ex_s    = 1'b1;
          if (drain_q <= DW'(1)) begin
            drain_d = DW'(0);
            state_d = HALT;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      HALT: begin
        stall_all_s = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (run_eval_s) begin
      state_d = RUN;
      if (memwait_s) begin
        stall_all_s = 1'b1;
        state_d     = MEMWAIT;
      end else if (ex_br_taken) begin
        // Wrong-path ID instruction: its load-use or HLT is discarded.
        flush_if_s = 1'b1;
        flush_ex_s = 1'b1;
      end else if (load_use_s) begin
        // Bubble for one cycle; a HLT in ID retries next cycle.
        stall_front_s = 1'b1;
        flush_ex_s    = 1'b1;
      end else if (id_halt) begin
        state_d = DRAIN;
        drain_d = DW'(DRAIN_CYC);
      end else begin
        state_d = RUN;
      end
    end else begin
      run_eval_s = 1'b0;
    end
  end

  // Saturating stall-cycle counter and registered halted flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    halted_d    = (state_d == HALT);
    if ((stall_front_s || stall_all_s) && (state_q != HALT) &&
        (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, drain counter, stall counter and halted flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= DW'(0);
      stall_cnt_q <= {CNT_W{1'b0}};
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign stall_PC     = stall_front_s | stall_all_s;
  assign stall_IF_ID  = stall_front_s | stall_all_s;
  assign stall_ID_EX  = stall_all_s;
  assign stall_EX_MEM = stall_all_s;
  assign stall_MEM_WB = stall_all_s;
  assign flush_IF_ID  = flush_if_s;
  assign flush_ID_EX  = flush_ex_s;
  assign halted       = halted_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all
// compared against a rule-level reference model. A 4-bit counter instance
// shares the stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] id_rs = 4'd0, id_rt = 4'd0, ex_rd = 4'd0;
  logic id_rs_vld = 1'b0, id_rt_vld = 1'b0, ex_load = 1'b0, ex_br_taken = 1'b0;
  logic mem_req = 1'b0, mem_rdy = 1'b0, id_halt = 1'b0;

  logic a_spc, a_sif, a_sid, a_sex, a_smw, a_fif, a_fid, a_halted;
  logic b_spc, b_sif, b_sid, b_sex, b_smw, b_fif, b_fid, b_halted;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit m_wait, m_halted;
  int m_left, m_cnt16, m_cnt4;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt),
    .id_rt_vld(id_rt_vld), .ex_load(ex_load), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_rdy(mem_rdy), .id_halt(id_halt),
    .stall_PC(a_spc), .stall_IF_ID(a_sif), .stall_ID_EX(a_sid), .stall_EX_MEM(a_sex),
    .stall_MEM_WB(a_smw), .flush_IF_ID(a_fif), .flush_ID_EX(a_fid),
    .halted(a_halted), .stall_cnt(a_cnt));

  pipe_hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt),
    .id_rt_vld(id_rt_vld), .ex_load(ex_load), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_rdy(mem_rdy), .id_halt(id_halt),
    .stall_PC(b_spc), .stall_IF_ID(b_sif), .stall_ID_EX(b_sid), .stall_EX_MEM(b_sex),
    .stall_MEM_WB(b_smw), .flush_IF_ID(b_fif), .flush_ID_EX(b_fid),
    .halted(b_halted), .stall_cnt(b_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_use();
    return ex_load && ex_rd != 4'd0 &&
           ((id_rs_vld && id_rs == ex_rd) || (id_rt_vld && id_rt == ex_rd));
  endfunction

  // Expected {stall PC, IF/ID, ID/EX, EX/MEM, MEM/WB, flush IF/ID, flush ID/EX}
  function automatic logic [6:0] model_out();
    bit waiting = mem_req && !mem_rdy;
    if (m_halted)                 return 7'b1111100;
    if (m_left > 0)               return waiting ? 7'b1111100 : 7'b1100001;
    if (m_wait && !mem_rdy)       return 7'b1111100;
    if (waiting)                  return 7'b1111100;
    if (ex_br_taken)              return 7'b0000011;
    if (load_use())               return 7'b1100001;
    return 7'b0000000;
  endfunction

  task automatic model_step(input logic [6:0] o);
    bit waiting = mem_req && !mem_rdy;
    if (o[6] && !m_halted) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (m_halted) begin
      // stays halted until reset
    end else if (m_left > 0) begin
      if (!waiting) begin
        m_left--;
        if (m_left == 0) m_halted = 1'b1;
      end
    end else if (m_wait && !mem_rdy) begin
      m_wait = 1'b1;
    end else begin
      m_wait = waiting;
      if (!waiting && !ex_br_taken && !load_use() && id_halt) m_left = 3;
    end
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_halted = 1'b0; m_left = 0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  task automatic clear_in();
    id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
    ex_load = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_rdy = 1'b0; id_halt = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, wait past the rising edge.
  task automatic cyc();
    logic [6:0] e;
    @(negedge clk);
    e = model_out();
    chk("outs", {a_spc, a_sif, a_sid, a_sex, a_smw, a_fif, a_fid}, e);
    chk("outs4", {b_spc, b_sif, b_sid, b_sex, b_smw, b_fif, b_fid}, e);
    chk("halted", a_halted, m_halted);
    chk("cnt16", a_cnt, m_cnt16);
    chk("cnt4", b_cnt, m_cnt4);
    model_step(e);
    @(posedge clk); #1;
  endtask

  // Assert reset between edges and check the effect before any clock edge.
  task automatic async_reset();
    @(posedge clk); #2;
    clear_in();
    rst = 1'b1;
    #1;
    chk("rst_outs", {a_spc, a_sif, a_sid, a_sex, a_smw, a_fif, a_fid, a_halted}, 8'h00);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_cnt4", b_cnt, 32'd0);
    chk("rst_halted4", b_halted, 1'b0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_in();
    #12;
    chk("por_outs", {a_spc, a_sif, a_sid, a_sex, a_smw, a_fif, a_fid, a_halted}, 8'h00);
    chk("por_cnt", a_cnt, 32'd0);
    rst = 1'b0;
    cyc();

    // load-use on rs: one-cycle bubble, counter 0 -> 1
    ex_load = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_rs_vld = 1'b1;
    cyc();
    clear_in(); cyc();
    chk("lu_cnt", a_cnt, 32'd1);
    // destination R0 never stalls
    ex_load = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_rs_vld = 1'b1; id_rt_vld = 1'b1;
    cyc();
    clear_in(); cyc();
    chk("r0_cnt", a_cnt, 32'd1);
    // load-use on rt
    ex_load = 1'b1; ex_rd = 4'd9; id_rt = 4'd9; id_rt_vld = 1'b1;
    cyc(); clear_in();
    // branch overriding load-use
    ex_load = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_rs_vld = 1'b1; ex_br_taken = 1'b1;
    cyc(); clear_in(); cyc();
    chk("br_cnt", a_cnt, 32'd2);

    // three-cycle memory wait, completion on the fourth
    mem_req = 1'b1;
    repeat (3) cyc();
    mem_rdy = 1'b1; cyc();
    clear_in(); cyc();
    chk("mw_cnt", a_cnt, 32'd5);
    // single-cycle access
    mem_req = 1'b1; mem_rdy = 1'b1; cyc(); clear_in();

    // halt with load-use pending: defer one cycle, then drain and halt
    id_halt = 1'b1; ex_load = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_vld = 1'b1;
    cyc();
    ex_load = 1'b0; cyc();
    clear_in();
    repeat (3) cyc();
    chk("halted_after_drain", a_halted, 1'b1);
    repeat (4) cyc();
    chk("halt_cnt", a_cnt, 32'd9);
    async_reset();
    cyc();

    // memwait in the middle of a drain freezes it for two cycles
    id_halt = 1'b1; cyc(); clear_in();
    cyc();
    mem_req = 1'b1; repeat (2) cyc(); clear_in();
    cyc();
    chk("dw_not_halted", a_halted, 1'b0);
    cyc();
    chk("dw_halted", a_halted, 1'b1);
    cyc();

    // reset in the middle of a drain
    async_reset();
    id_halt = 1'b1; cyc(); clear_in(); cyc();
    async_reset();
    cyc();

    // 20 stall cycles saturate the 4-bit counter, then halt and reset from HALT
    mem_req = 1'b1; repeat (20) cyc(); clear_in();
    chk("sat4", b_cnt, 32'd15);
    id_halt = 1'b1; cyc(); clear_in();
    repeat (5) cyc();
    chk("sat4_hold", b_cnt, 32'd15);
    async_reset();
    cyc();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) async_reset();
      id_rs = 4'($urandom_range(0, 3)); id_rt = 4'($urandom_range(0, 3));
      ex_rd = 4'($urandom_range(0, 3));
      id_rs_vld = 1'($urandom_range(0, 1)); id_rt_vld = 1'($urandom_range(0, 1));
      ex_load = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 4) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_rdy = ($urandom_range(0, 1) == 0);
      id_halt = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Combines four hazard sources into per-stage stall and flush controls:
  - load-use data hazards
  - taken-branch redirects
  - multi-cycle data-memory waits
  - halt drain
- Also holds a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.
- DRAIN_CYC, 3, cycles to drain after a halt leaves ID (EX, MEM, WB).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- id_rs, input, 4, source register 1 of the instruction in ID.
- id_rs_vld, input, 1, ID instruction reads id_rs.
- id_rt, input, 4, source register 2 of the instruction in ID.
- id_rt_vld, input, 1, ID instruction reads id_rt.
- ex_load, input, 1, instruction in EX is a load.
- ex_rd, input, 4, destination register of the instruction in EX.
- ex_br_taken, input, 1, branch or jump in EX resolved taken.
- mem_req, input, 1, MEM stage has an access in flight.
- mem_rdy, input, 1, data memory completes the access this cycle.
- id_halt, input, 1, instruction in ID is HLT.
- stall_PC, output, 1, hold PC.
- stall_IF_ID, output, 1, hold IF/ID register.
- stall_ID_EX, output, 1, hold ID/EX register.
- stall_EX_MEM, output, 1, hold EX/MEM register.
- stall_MEM_WB, output, 1, hold MEM/WB register.
- flush_IF_ID, output, 1, load NOP into IF/ID.
- flush_ID_EX, output, 1, load NOP (bubble) into ID/EX.
- halted, output, 1, pipeline fully drained after HLT.
- stall_cnt, output, CNT_W, count of cycles with stall_PC high.

Behaviour:
- States: RUN, MEMWAIT, DRAIN, HALT. Stall and flush outputs are combinational from state and inputs. State, drain counter and stall_cnt are registered.
- Reset: async, state goes to RUN; drain counter, stall_cnt and halted go to 0. With all inputs low, every stall and flush output is 0. Reset mid-operation (including DRAIN or HALT) returns to RUN the same way.
- Priority in RUN: memwait > branch > load-use > halt.
- Memwait:
  - Condition: mem_req=1 and mem_rdy=0.
  - Response: all five stalls = 1, no flushes; go to MEMWAIT.
  - In MEMWAIT, all stalls stay 1 until the cycle with mem_rdy=1. In that cycle all stalls = 0 and the other hazard terms are evaluated as in RUN; next state is RUN.
  - A single-cycle access (mem_req=1 and mem_rdy=1 in the same cycle) causes no stall.
- Branch:
  - ex_br_taken=1 with no memwait gives flush_IF_ID=1 and flush_ID_EX=1, with no stalls.
  - Branch suppresses load-use and halt, because the ID instruction is on the wrong path.
- Load-use:
  - Hazard when ex_load=1, ex_rd != 0, and either (id_rs_vld and id_rs==ex_rd) or (id_rt_vld and id_rt==ex_rd).
  - Response: stall_PC=1, stall_IF_ID=1, flush_ID_EX=1 for exactly one cycle; the load then advances to MEM.
  - R0 is hardwired zero, so ex_rd==0 never stalls.
- Halt:
  - id_halt=1 in RUN with no higher-priority event and no load-use hazard moves to DRAIN, with the drain counter set to DRAIN_CYC. The HLT itself advances into EX that cycle.
  - If a load-use hazard is present, entry to DRAIN is deferred to the next cycle.
- DRAIN:
  - stall_PC=1, stall_IF_ID=1, flush_ID_EX=1.
  - The counter decrements each cycle; at 0, go to HALT.
  - A memwait condition in DRAIN asserts all stalls, freezes the counter, and keeps the state at DRAIN; the MEMWAIT state is not entered.
  - ex_br_taken is ignored in DRAIN.
- HALT: all five stalls = 1, halted=1. The only exit is rst.
- stall_cnt:
  - Increments on each clock edge where stall_PC=1 and state != HALT.
  - Saturates at all-ones and does not wrap.

Test Plan:
- Load-use: ex_load=1, ex_rd=5, id_rs=5, id_rs_vld=1 for one cycle -> stall_PC, stall_IF_ID and flush_ID_EX high for 1 cycle; stall_cnt goes 0->1. Repeat with ex_rd=0 -> no stall, stall_cnt unchanged.
- Branch with simultaneous load-use: ex_br_taken=1 in the same cycle as a matching load-use -> flush_IF_ID=1, flush_ID_EX=1, stall_PC=0, stall_cnt unchanged.
- Memwait: mem_req=1 with mem_rdy=0 for 3 cycles, then mem_rdy=1 -> all five stalls high for 3 cycles and low in the 4th; stall_cnt=3.
- Halt drain: id_halt=1 in RUN with DRAIN_CYC=3 -> 3 cycles of stall_PC=1 and flush_ID_EX=1, then halted=1 and all stalls high indefinitely; stall_cnt stops at 3.
- Memwait during DRAIN: mem_req=1, mem_rdy=0 for 2 cycles in the middle of a drain -> counter frozen; halted asserts 2 cycles later than without the wait.
- Reset: assert rst mid-DRAIN, and separately from HALT with CNT_W=4 after 20 stall cycles -> before the reset stall_cnt holds at 15; after the reset, state is RUN, halted=0, stall_cnt=0 and all outputs are 0, asynchronously without waiting for a clock edge.
